// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data memory.
// Data requests take priority. After STARVE_MAX consecutive data grants made
// while iREN waits, the next grant goes to fetch. STARVE_MAX=0 disables that
// guard and gives pure data priority.
// Each transaction walks IDLE -> IBUSY/DBUSY -> DONE, so back-to-back requests
// complete at most once every three cycles. Every output is a register or a
// decode of the latched request; no input reaches an output combinationally.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   iREN, iaddr          fetch request (level) and address
//   ihit, iload          fetch-complete pulse, fetched word (held)
//   dREN, dWEN           data read / write request (level), dWEN wins if both
//   daddr, dstore        data address and write data
//   dhit, dload          data-complete pulse, read data (held)
//   ramREN, ramWEN       RAM strobes, only active in a busy state
//   ramaddr, ramstore    RAM address and write data, taken from the latches
//   ramload, ram_ready   RAM read data, access-complete flag
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready
);

  localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_FETCH, OP_READ, OP_WRITE} op_t;

  state_t            state_q;
  op_t               op_q;
  logic [CW-1:0]     cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              ihit_q, dhit_q;
  logic [DATA_W-1:0] iload_q, dload_q;
  logic              ramren_q, ramwen_q;

  logic d_pend;
  logic starved;

  assign d_pend  = dREN | dWEN;
  // The starvation guard only bites while fetch is actually waiting, so
  // data is never blocked when iREN has gone low.
  assign starved = (STARVE_MAX != 0) && iREN && (cnt_q == SMAX);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      op_q     <= OP_FETCH;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      ihit_q   <= 1'b0;
      dhit_q   <= 1'b0;
      iload_q  <= '0;
      dload_q  <= '0;
      ramren_q <= 1'b0;
      ramwen_q <= 1'b0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (d_pend && !starved) begin
            state_q <= DBUSY;
            addr_q  <= daddr;
            data_q  <= dstore;
            if (dWEN) begin
              op_q     <= OP_WRITE;
              ramwen_q <= 1'b1;
            end else begin
              op_q     <= OP_READ;
              ramren_q <= 1'b1;
            end
            if (iREN && (cnt_q != SMAX)) cnt_q <= cnt_q + CW'(1);
          end else if (iREN) begin
            state_q  <= IBUSY;
            addr_q   <= iaddr;
            op_q     <= OP_FETCH;
            ramren_q <= 1'b1;
            cnt_q    <= '0;
          end
        end
        IBUSY, DBUSY: begin
          // Requester inputs are deliberately ignored here; the access runs
          // to completion on the latched address, data and op.
          if (ram_ready) begin
            state_q  <= DONE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            unique case (op_q)
              OP_FETCH: begin
                iload_q <= ramload;
                ihit_q  <= 1'b1;
              end
              OP_READ: begin
                dload_q <= ramload;
                dhit_q  <= 1'b1;
              end
              OP_WRITE: dhit_q <= 1'b1;
              default: ;
            endcase
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign iload    = iload_q;
  assign dload    = dload_q;
  assign ramREN   = ramren_q;
  assign ramWEN   = ramwen_q;
  assign ramaddr  = addr_q;
  assign ramstore = data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. The main instance uses STARVE_MAX=3. A second
// instance with STARVE_MAX=0 shares the same stimulus and is checked only in
// the priority window. Each expected hit is queued by the stimulus, and a
// monitor process pops and checks the queue on every hit.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        ihit, dhit, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit0, dhit0, ramREN0, ramWEN0;
  logic [31:0] iload0, dload0, ramaddr0, ramstore0;

  mem_arbiter #(.STARVE_MAX(3), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  mem_arbiter #(.STARVE_MAX(0), .ADDR_W(32), .DATA_W(32)) dut0 (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .ihit(ihit0), .iload(iload0),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dhit(dhit0), .dload(dload0),
    .ramREN(ramREN0), .ramWEN(ramWEN0), .ramaddr(ramaddr0), .ramstore(ramstore0),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        is_i;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic win0   = 1'b0;
  int   i0 = 0, d0 = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic is_i, input logic [31:0] data);
    exp_t e;
    e.is_i = is_i;
    e.data = data;
    q.push_back(e);
  endtask

  task automatic mon_step();
    exp_t e;
    if (nRST) begin
      if (ramREN || ramWEN) chk("strobes_exclusive", {ramREN, ramWEN} != 2'b11, 1'b1);
      if (ihit || dhit) begin
        chk("hits_exclusive", {ihit, dhit} != 2'b11, 1'b1);
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit: got ihit=%0b dhit=%0b expected no hit", ihit, dhit);
        end else begin
          e = q.pop_front();
          chk("hit_kind_is_fetch", ihit, e.is_i);
          chk("hit_data", ihit ? iload : dload, e.data);
        end
      end
      if (win0) begin
        if (ihit0) i0++;
        if (dhit0) begin
          d0++;
          chk("dut0_dload", dload0, 32'h0000A5A5);
        end
        chk("dut0_ramWEN", ramWEN0, 1'b0);
        if (ramREN0) begin
          chk("dut0_ramaddr", ramaddr0, 32'h200);
          chk("dut0_ramstore", ramstore0, 32'h0);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nh, td, ti, wcnt;
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ram_ready = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;

    fork
      forever begin
        @(negedge CLK);
        mon_step();
      end
    join_none

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ihit", ihit, 0);      chk("rst_dhit", dhit, 0);
    chk("rst_iload", iload, 0);    chk("rst_dload", dload, 0);
    chk("rst_ramREN", ramREN, 0);  chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0); chk("rst_ramstore", ramstore, 0);

    // Fetch only
    nRST = 1'b1;
    ram_ready = 1'b1; ramload = 32'h8C220004;
    iREN = 1'b1; iaddr = 32'h40;
    push(1'b1, 32'h8C220004);
    tick();
    chk("fetch_ramREN", ramREN, 1);
    chk("fetch_ramWEN", ramWEN, 0);
    chk("fetch_ramaddr", ramaddr, 32'h40);
    tick();
    chk("fetch_ihit_2cyc", ihit, 1);
    iREN = 1'b0;
    tick();
    chk("fetch_ihit_pulse", ihit, 0);
    chk("done_no_strobe", ramREN, 0);
    tick();

    // Data write with three wait cycles; dWEN wins over dREN
    ram_ready = 1'b0; ramload = 32'h11111111;
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    push(1'b0, 32'h0);
    tick();
    chk("wr_ramaddr", ramaddr, 32'h100);
    chk("wr_ramstore", ramstore, 32'hDEADBEEF);
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (ramWEN && !ramREN) wcnt++;
      if (i == 3) ram_ready = 1'b1;
      tick();
    end
    chk("wr_strobe_cycles", wcnt, 4);
    chk("wr_dhit", dhit, 1);
    chk("wr_ramWEN_off", ramWEN, 0);
    dREN = 1'b0; dWEN = 1'b0;
    tick();
    chk("wr_dhit_pulse", dhit, 0);
    chk("wr_dload_unchanged", dload, 0);
    tick();

    // Priority and starvation, with STARVE_MAX=3 and STARVE_MAX=0 side by side
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    ram_ready = 1'b1; ramload = 32'h0000A5A5;
    iaddr = 32'h80; daddr = 32'h200; dstore = 32'h0;
    iREN = 1'b1; dREN = 1'b1;
    win0 = 1'b1;
    push(1'b0, 32'hA5A5); push(1'b0, 32'hA5A5); push(1'b0, 32'hA5A5); push(1'b1, 32'hA5A5);
    push(1'b0, 32'hA5A5); push(1'b0, 32'hA5A5); push(1'b0, 32'hA5A5); push(1'b1, 32'hA5A5);
    nh = 0;
    for (int c = 0; c < 60 && nh < 8; c++) begin
      tick();
      if (ihit || dhit) nh++;
    end
    chk("starve_hit_count", nh, 8);
    iREN = 1'b0; dREN = 1'b0;
    tick();
    tick();
    win0 = 1'b0;
    chk("dut0_fetch_hits", i0, 0);
    chk("dut0_data_hits", d0, 8);
    chk("dut0_iload", iload0, 0);

    // Request withdrawn while busy
    ram_ready = 1'b0; ramload = 32'h12345678;
    dREN = 1'b1; daddr = 32'h300;
    push(1'b0, 32'h12345678);
    push(1'b1, 32'h12345678);
    tick();
    dREN = 1'b0; daddr = 32'h999;
    iREN = 1'b1; iaddr = 32'h44;
    tick();
    chk("wd_ramREN_held", ramREN, 1);
    chk("wd_ramaddr_held", ramaddr, 32'h300);
    ram_ready = 1'b1;
    tick();
    chk("wd_dhit", dhit, 1);
    chk("wd_no_grant_in_done", ramREN, 0);
    tick();
    chk("wd_idle_no_strobe", ramREN, 0);
    tick();
    chk("wd_next_fetch_ramREN", ramREN, 1);
    chk("wd_next_fetch_addr", ramaddr, 32'h44);
    tick();
    chk("wd_ihit", ihit, 1);
    iREN = 1'b0;
    tick();
    tick();

    // Asynchronous reset during a data access
    ram_ready = 1'b0; ramload = 32'h0BADF00D;
    dREN = 1'b1; daddr = 32'h500;
    tick();
    chk("ar_busy_ramREN", ramREN, 1);
    #2 nRST = 1'b0;
    #1;
    chk("ar_ramREN", ramREN, 0);
    chk("ar_ramaddr", ramaddr, 0);
    chk("ar_dhit", dhit, 0);
    chk("ar_dload", dload, 0);
    chk("ar_iload", iload, 0);
    dREN = 1'b0; ram_ready = 1'b1;
    iREN = 1'b1; iaddr = 32'h60;
    push(1'b1, 32'h0BADF00D);
    tick();
    nRST = 1'b1;
    ti = -1;
    for (int c = 0; c < 10 && ti < 0; c++) begin
      tick();
      if (ihit) ti = c;
    end
    chk("ar_fetch_completes", ti >= 0, 1);
    iREN = 1'b0;
    tick();
    tick();

    // Simultaneous arrival at reset release
    nRST = 1'b0;
    ramload = 32'hCAFEF00D; ram_ready = 1'b1;
    iREN = 1'b1; iaddr = 32'h70;
    dREN = 1'b1; daddr = 32'h600;
    push(1'b0, 32'hCAFEF00D);
    push(1'b1, 32'hCAFEF00D);
    tick();
    nRST = 1'b1;
    td = -1; ti = -1;
    for (int c = 0; c < 20 && ti < 0; c++) begin
      tick();
      if (dhit && td < 0) begin
        td = c;
        dREN = 1'b0;
      end
      if (ihit && ti < 0) begin
        ti = c;
        iREN = 1'b0;
      end
    end
    chk("sim_dhit_seen", td >= 0, 1);
    chk("sim_ihit_seen", ti >= 0, 1);
    chk("sim_ihit_gap_ge3", (ti - td) >= 3, 1);
    repeat (3) tick();

    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
